// File: rtl/loom_fifo_pkg.sv
// Shared defaults and width helpers for the loom handshake FIFO.
// Optional same-cycle bypass is enabled by defining LOOM_FIFO_BYPASS_EN.
package loom_fifo_pkg;

   localparam int DEF_DATA_WIDTH = 32;
   localparam int DEF_DEPTH      = 4;

   // Occupancy must be able to represent both 0 and DEPTH.
   function automatic int cnt_width(input int depth);
      return $clog2(depth + 1);
   endfunction

   function automatic int ptr_width(input int depth);
      return (depth <= 2) ? 1 : $clog2(depth);
   endfunction

endpackage

// File: rtl/fifo_wrap_ptr.sv
// FIFO pointer: increments on i_inc, wraps from DEPTH-1 to 0 for any DEPTH,
// and clears synchronously on i_clr (clear has priority over increment).
module fifo_wrap_ptr
   import loom_fifo_pkg::*;
#(
   parameter int DEPTH = DEF_DEPTH,
   parameter int PTR_W = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_clr,
   input  logic             i_inc,
   output logic [PTR_W-1:0] o_ptr
);

   logic [PTR_W-1:0] r_ptr;
   logic             w_last;

   assign w_last = (r_ptr == PTR_W'(DEPTH - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_clr) begin
         r_ptr <= '0;
      end else if (i_inc) begin
         r_ptr <= w_last ? '0 : r_ptr + PTR_W'(1);
      end
   end

   assign o_ptr = r_ptr;

endmodule

// File: rtl/handshake_fifo.sv
// Valid/ready FIFO with occupancy count, almost_full and synchronous flush.
// Define LOOM_FIFO_BYPASS_EN to forward input to output when empty.
module handshake_fifo
   import loom_fifo_pkg::*;
#(
   parameter  int DATA_WIDTH = DEF_DATA_WIDTH,
   parameter  int DEPTH      = DEF_DEPTH,
   parameter  int AF_THRESH  = DEPTH - 1,
   localparam int CNT_W      = cnt_width(DEPTH),
   localparam int PTR_W      = ptr_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic [CNT_W-1:0]      count,
   output logic                  almost_full
);

   logic [DATA_WIDTH-1:0] r_mem [DEPTH];
   logic [CNT_W-1:0]      r_count;
   logic [PTR_W-1:0]      w_wptr;
   logic [PTR_W-1:0]      w_rptr;
   logic                  w_empty;
   logic                  w_full;
   logic                  w_wr;
   logic                  w_rd;

   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CNT_W'(DEPTH));

   // Ready depends only on registered occupancy and flush, never on out_ready.
   assign in_ready = !w_full && !flush;

`ifdef LOOM_FIFO_BYPASS_EN
   logic w_byp;

   assign w_byp     = w_empty && in_valid && in_ready;
   assign out_valid = !w_empty || w_byp;
   assign out_data  = w_empty ? in_data : r_mem[w_rptr];
   // A bypassed word taken in the same cycle never touches storage.
   assign w_wr      = in_valid && in_ready && !(w_byp && out_ready);
   assign w_rd      = !w_empty && out_ready;
`else
   assign out_valid = !w_empty;
   assign out_data  = r_mem[w_rptr];
   assign w_wr      = in_valid && in_ready;
   assign w_rd      = out_valid && out_ready;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (flush) begin
         r_count <= '0;
      end else begin
         case ({w_wr, w_rd})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is intentionally not reset; out_data is don't-care while empty.
   always_ff @(posedge clk) begin
      if (w_wr) begin
         r_mem[w_wptr] <= in_data;
      end
   end

   fifo_wrap_ptr #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_wptr (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (flush),
      .i_inc (w_wr),
      .o_ptr (w_wptr)
   );

   fifo_wrap_ptr #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_rptr (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (flush),
      .i_inc (w_rd),
      .o_ptr (w_rptr)
   );

   assign count       = r_count;
   assign almost_full = (r_count >= CNT_W'(AF_THRESH));

endmodule
